// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Two-requester arbiter and command sequencer for the SPI slave's single-port
// RAM. Each granted transaction becomes a short burst of 10-bit command words
// {op[1:0], payload}:
//    write : {00, addr}  then {01, wdata}
//    read  : {10, addr}  then {11, 0}, then wait for ram_tx_valid
// The owning requester then gets a one-cycle ack. Read data is held in that
// port's rdata register.
//
// Build option:
//    RAM_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                   undefined -> fixed priority, port A always wins
//
// Parameters:
//    ADDR_SIZE  RAM address width (must not exceed WORD_SIZE)
//    WORD_SIZE  RAM data word width
//
// Ports:
//    clk, rst_n              clock, synchronous active-low reset
//    a_req/a_we/a_addr/a_wdata   port A transaction request (held until a_ack)
//    a_ack, a_rdata          port A completion pulse and read data
//    b_*                     same as port A, for port B
//    ram_rx_valid, ram_din   command word strobe and word to the RAM
//    ram_tx_valid, ram_dout  read data returned by the RAM
//    busy                    high whenever a transaction is in flight
//    owner                   current or last granted port (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDR_SIZE-1:0] a_addr,
   input  logic [WORD_SIZE-1:0] a_wdata,
   output logic                 a_ack,
   output logic [WORD_SIZE-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_SIZE-1:0] b_addr,
   input  logic [WORD_SIZE-1:0] b_wdata,
   output logic                 b_ack,
   output logic [WORD_SIZE-1:0] b_rdata,
   output logic                 ram_rx_valid,
   output logic [WORD_SIZE+1:0] ram_din,
   input  logic                 ram_tx_valid,
   input  logic [WORD_SIZE-1:0] ram_dout,
   output logic                 busy,
   output logic                 owner
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_DATA    = 3'd2,
      ST_WAIT_RD = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_WDATA = 2'b01;
   localparam logic [1:0] OP_RADDR = 2'b10;
   localparam logic [1:0] OP_RTRIG = 2'b11;

   // Pack an opcode and payload into one RAM command word.
   function automatic logic [WORD_SIZE+1:0] cmd_word(input logic [1:0]           op,
                                                     input logic [WORD_SIZE-1:0] payload);
      return {op, payload};
   endfunction

   state_t                 state_q,    state_d;
   logic                   we_q,       we_d;
   logic [ADDR_SIZE-1:0]   addr_q,     addr_d;
   logic [WORD_SIZE-1:0]   wdata_q,    wdata_d;
   logic                   owner_q,    owner_d;
   logic                   a_ack_q,    a_ack_d;
   logic                   b_ack_q,    b_ack_d;
   logic [WORD_SIZE-1:0]   a_rdata_q,  a_rdata_d;
   logic [WORD_SIZE-1:0]   b_rdata_q,  b_rdata_d;
   logic                   rx_valid_q, rx_valid_d;
   logic [WORD_SIZE+1:0]   din_q,      din_d;
   logic                   busy_q,     busy_d;
   logic                   grant_b_s;

`ifdef RAM_ARB_RR_EN
   // prio_b_q set means B wins the next contention (A was served last).
   logic                   prio_b_q,   prio_b_d;

   assign grant_b_s = b_req & (~a_req | prio_b_q);
`else
   assign grant_b_s = b_req & ~a_req;
`endif

   // Next-state and next-output logic. Outputs are computed one state ahead
   // so that every output comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      owner_d    = owner_q;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      rx_valid_d = 1'b0;
      din_d      = {(WORD_SIZE+2){1'b0}};
`ifdef RAM_ARB_RR_EN
      prio_b_d   = prio_b_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (a_req | b_req) begin
               owner_d = grant_b_s;
               if (grant_b_s) begin
                  we_d    = b_we;
                  addr_d  = b_addr;
                  wdata_d = b_wdata;
               end else begin
                  we_d    = a_we;
                  addr_d  = a_addr;
                  wdata_d = a_wdata;
               end
`ifdef RAM_ARB_RR_EN
               prio_b_d = ~grant_b_s;
`endif
               // Address word goes out in the ADDR cycle.
               rx_valid_d = 1'b1;
               din_d      = cmd_word(we_d ? OP_WADDR : OP_RADDR, WORD_SIZE'(addr_d));
               state_d    = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ADDR: begin
            // Data word (write) or read trigger goes out in the DATA cycle.
            rx_valid_d = 1'b1;
            if (we_q) begin
               din_d = cmd_word(OP_WDATA, wdata_q);
            end else begin
               din_d = cmd_word(OP_RTRIG, {WORD_SIZE{1'b0}});
            end
            state_d = ST_DATA;
         end

         ST_DATA: begin
            if (we_q) begin
               a_ack_d = ~owner_q;
               b_ack_d = owner_q;
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT_RD;
            end
         end

         ST_WAIT_RD: begin
            // No timeout: a read waits as long as the RAM takes.
            if (ram_tx_valid) begin
               if (owner_q) begin
                  b_rdata_d = ram_dout;
                  b_ack_d   = 1'b1;
               end else begin
                  a_rdata_d = ram_dout;
                  a_ack_d   = 1'b1;
               end
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT_RD;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         addr_q     <= {ADDR_SIZE{1'b0}};
         wdata_q    <= {WORD_SIZE{1'b0}};
         owner_q    <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rdata_q  <= {WORD_SIZE{1'b0}};
         b_rdata_q  <= {WORD_SIZE{1'b0}};
         rx_valid_q <= 1'b0;
         din_q      <= {(WORD_SIZE+2){1'b0}};
         busy_q     <= 1'b0;
`ifdef RAM_ARB_RR_EN
         prio_b_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         owner_q    <= owner_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         rx_valid_q <= rx_valid_d;
         din_q      <= din_d;
         busy_q     <= busy_d;
`ifdef RAM_ARB_RR_EN
         prio_b_q   <= prio_b_d;
`endif
      end
   end

   assign a_ack        = a_ack_q;
   assign b_ack        = b_ack_q;
   assign a_rdata      = a_rdata_q;
   assign b_rdata      = b_rdata_q;
   assign ram_rx_valid = rx_valid_q;
   assign ram_din      = din_q;
   assign busy         = busy_q;
   assign owner        = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter. A small RAM model answers the command words.
// A transaction-level reference model predicts every output on every cycle from
// the grant time and the transaction type. Directed tests also pin a few
// literal values: latencies, command words and grant order.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_req, a_we, b_req, b_we;
   logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
   logic       a_ack, b_ack;
   logic [7:0] a_rdata, b_rdata;
   logic       ram_rx_valid;
   logic [9:0] ram_din;
   logic       ram_tx_valid = 1'b0;
   logic [7:0] ram_dout = 8'h00;
   logic       busy, owner;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rd_extra = 0;

   ram_arbiter #(.ADDR_SIZE(8), .WORD_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
      .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // RAM model. It shares the reset, so a word presented while rst_n is low is
   // ignored. Read data comes back one cycle after the trigger word, plus
   // rd_extra cycles.
   logic [7:0] ram_mem [256] = '{default: 8'h00};
   logic [7:0] ram_wa = 8'h00, ram_ra = 8'h00, pend_data = 8'h00;
   int         pend_cnt = 0;

   always @(posedge clk) begin
      ram_tx_valid <= 1'b0;
      if (!rst_n) begin
         pend_cnt <= 0;
      end else begin
         if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
               ram_tx_valid <= 1'b1;
               ram_dout     <= pend_data;
            end
         end
         if (ram_rx_valid) begin
            case (ram_din[9:8])
               2'b00: ram_wa <= ram_din[7:0];
               2'b01: ram_mem[ram_wa] <= ram_din[7:0];
               2'b10: ram_ra <= ram_din[7:0];
               default: begin
                  if (rd_extra == 0) begin
                     ram_tx_valid <= 1'b1;
                     ram_dout     <= ram_mem[ram_ra];
                  end else begin
                     pend_cnt  <= rd_extra;
                     pend_data <= ram_mem[ram_ra];
                  end
               end
            endcase
         end
      end
   end

   // Reference model and per-cycle compare. At the negedge of cycle k it checks
   // the outputs of cycle k. It then consumes the inputs that the edge ending
   // cycle k will sample.
   initial begin : model_blk
      bit         started, act, m_we, m_port, m_owner, m_last_b, win;
      int         t0, ack_c, k;
      logic [7:0] m_addr, m_wd, m_rd, m_ard, m_brd;
      logic [7:0] m_mem [256];
      logic [9:0] e_din;
      bit         e_rxv, e_busy, e_aack, e_back;
      started = 0; act = 0; m_owner = 0; m_last_b = 1; t0 = 0; ack_c = 0;
      m_ard = 8'h00; m_brd = 8'h00; m_we = 0; m_port = 0;
      m_addr = 8'h00; m_wd = 8'h00; m_rd = 8'h00;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      forever begin
         @(negedge clk);
         k = cyc;
         if (started) begin
            e_rxv = 0; e_din = 10'h000; e_busy = 0; e_aack = 0; e_back = 0;
            if (act) begin
               e_busy = (k > t0);
               if (k == t0 + 1) begin
                  e_rxv = 1;
                  e_din = {(m_we ? 2'b00 : 2'b10), m_addr};
               end else if (k == t0 + 2) begin
                  e_rxv = 1;
                  e_din = m_we ? {2'b01, m_wd} : {2'b11, 8'h00};
               end
               if (k == ack_c) begin
                  e_aack = !m_port;
                  e_back = m_port;
                  if (!m_we) begin
                     if (m_port) m_brd = m_rd;
                     else        m_ard = m_rd;
                  end
               end
            end
            chk("m_rxv",     ram_rx_valid, e_rxv);
            chk("m_din",     ram_din,      e_din);
            chk("m_busy",    busy,         e_busy);
            chk("m_a_ack",   a_ack,        e_aack);
            chk("m_b_ack",   b_ack,        e_back);
            chk("m_a_rdata", a_rdata,      m_ard);
            chk("m_b_rdata", b_rdata,      m_brd);
            chk("m_owner",   owner,        m_owner);
         end
         // A write reaches the RAM when its data word goes out without reset.
         if (rst_n && act && m_we && k == t0 + 2) m_mem[m_addr] = m_wd;
         if (!rst_n) begin
            started = 1; act = 0; m_owner = 0; m_last_b = 1;
            m_ard = 8'h00; m_brd = 8'h00;
         end else if (act && k == ack_c) begin
            act = 0;
         end else if (!act && (a_req || b_req)) begin
`ifdef RAM_ARB_RR_EN
            win = (a_req && b_req) ? !m_last_b : b_req;
`else
            win = !a_req;
`endif
            m_port   = win;
            m_we     = win ? b_we : a_we;
            m_addr   = win ? b_addr : a_addr;
            m_wd     = win ? b_wdata : a_wdata;
            m_rd     = m_mem[m_addr];
            t0       = k;
            ack_c    = m_we ? k + 3 : k + 4 + rd_extra;
            m_owner  = win;
            m_last_b = win;
            act      = 1;
         end
      end
   end

   // Run one transaction on one port. Return its latency, the command words
   // seen 1 and 2 cycles after the grant (10'h3FF when the strobe is low), and
   // the busy and strobe values 5 cycles after the grant.
   task automatic run_txn(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, output int lat,
                          output logic [9:0] w1, output logic [9:0] w2,
                          output logic mid_busy, output logic mid_rxv);
      int t0;
      bit got;
      @(posedge clk); #1;
      if (port) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
      t0 = cyc; got = 0; lat = -1;
      w1 = 10'h3FF; w2 = 10'h3FF; mid_busy = 1'b0; mid_rxv = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (cyc - t0 == 1) w1 = ram_rx_valid ? ram_din : 10'h3FF;
         if (cyc - t0 == 2) w2 = ram_rx_valid ? ram_din : 10'h3FF;
         if (cyc - t0 == 5) begin
            mid_busy = busy;
            mid_rxv  = ram_rx_valid;
         end
         if ((port && b_ack) || (!port && a_ack)) begin
            got = 1;
            lat = cyc - t0;
         end
      end
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (port) b_req = 1'b0;
      else      a_req = 1'b0;
   endtask

   initial begin : wdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int         lat, n;
      logic [9:0] w1, w2;
      logic       mb, mr;
      logic [3:0] order;
      int         ack_at [3];
      rst_n = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
      b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_ack",   a_ack,        1'b0);
      chk("rst_b_ack",   b_ack,        1'b0);
      chk("rst_a_rdata", a_rdata,      8'h00);
      chk("rst_b_rdata", b_rdata,      8'h00);
      chk("rst_rxv",     ram_rx_valid, 1'b0);
      chk("rst_din",     ram_din,      10'h000);
      chk("rst_busy",    busy,         1'b0);
      chk("rst_owner",   owner,        1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // A writes 0x3C <- 0xA5.
      run_txn(1'b0, 1'b1, 8'h3C, 8'hA5, lat, w1, w2, mb, mr);
      chk("wr_latency", lat, 3);
      chk("wr_word1",   w1,  10'h03C);
      chk("wr_word2",   w2,  10'h1A5);

      // A reads 0x3C back.
      run_txn(1'b0, 1'b0, 8'h3C, 8'h00, lat, w1, w2, mb, mr);
      chk("rd_latency", lat,     4);
      chk("rd_word1",   w1,      10'h23C);
      chk("rd_word2",   w2,      10'h300);
      chk("rd_a_rdata", a_rdata, 8'hA5);
      chk("rd_b_rdata", b_rdata, 8'h00);

      // B reads 0x3C with the RAM answering 5 cycles late.
      rd_extra = 5;
      run_txn(1'b1, 1'b0, 8'h3C, 8'h00, lat, w1, w2, mb, mr);
      rd_extra = 0;
      chk("slow_latency", lat,     9);
      chk("slow_busy",    mb,      1'b1);
      chk("slow_rxv",     mr,      1'b0);
      chk("slow_b_rdata", b_rdata, 8'hA5);
      chk("slow_a_rdata", a_rdata, 8'hA5);

      // Both ports request writes continuously for 16 cycles.
      @(posedge clk); #1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 8'h01;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h41; b_wdata = 8'h02;
      n = 0; order = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (a_ack && n < 4) begin order[n] = 1'b0; n++; end
         if (b_ack && n < 4) begin order[n] = 1'b1; n++; end
      end
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0;
      chk("cont_acks", n, 4);
`ifdef RAM_ARB_RR_EN
      chk("cont_order", order, 4'b1010);
`else
      chk("cont_order", order, 4'b0000);
`endif

      // Back-to-back A writes with a_req held.
      @(posedge clk); #1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'h11;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_ack && n < 3) begin ack_at[n] = i; n++; end
      end
      @(posedge clk); #1;
      a_req = 1'b0;
      chk("b2b_acks", n, 3);
      if (n == 3) begin
         chk("b2b_ack0", ack_at[0], 3);
         chk("b2b_ack1", ack_at[1], 7);
         chk("b2b_ack2", ack_at[2], 11);
      end

      // Reset during the DATA cycle of an A write of 0x77 to 0x10.
      @(posedge clk); #1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h77;
      @(posedge clk); #1;
      a_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_data_word", ram_din, 10'h177);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_rxv",     ram_rx_valid, 1'b0);
      chk("abort_din",     ram_din,      10'h000);
      chk("abort_busy",    busy,         1'b0);
      chk("abort_a_ack",   a_ack,        1'b0);
      chk("abort_a_rdata", a_rdata,      8'h00);
      chk("abort_b_rdata", b_rdata,      8'h00);
      chk("abort_owner",   owner,        1'b0);
      run_txn(1'b0, 1'b0, 8'h10, 8'h00, lat, w1, w2, mb, mr);
      chk("abort_rd_latency", lat,     4);
      chk("abort_rd_data",    a_rdata, 8'h00);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
